// File: rtl/rca_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one external 4-bit ripple-carry adder.
// Optional subtract mode (A-B via ~B and carry-in 1) is enabled by defining RCA_SEQ_SUB_EN.
module rca_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic [3:0]       adder_a,
   output logic [3:0]       adder_b,
   output logic             adder_cin,
   input  logic [3:0]       adder_sum,
   input  logic             adder_cout
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int LAST    = NIBBLES - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   logic [WIDTH-1:0]   b_in;
   logic               cin_in;

`ifdef RCA_SEQ_SUB_EN
   assign b_in   = in_sub ? ~in_b : in_b;
   assign cin_in = in_sub ? 1'b1 : in_cin;
`else
   assign b_in   = in_b;
   assign cin_in = in_cin;
`endif

   assign out_sum  = sum_q;
   assign out_cout = cout_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      adder_a   = 4'h0;
      adder_b   = 4'h0;
      adder_cin = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = b_in;
               carry_d = cin_in;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            adder_a   = a_q[4*idx_q +: 4];
            adder_b   = b_q[4*idx_q +: 4];
            adder_cin = carry_q;
            sum_d[4*idx_q +: 4] = adder_sum;
            carry_d = adder_cout;
            // Index wraps to 0 after the top nibble so it is already clean for the next op.
            if (idx_q == IDX_W'(LAST)) begin
               cout_d  = adder_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

endmodule
